// File: rtl/cam_stream_pkg.sv
// Shared types and constants for the CAM streaming path: packet layout,
// flag positions, fixed addresses and the arbiter state encoding.
package cam_stream_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  flags;
  } packet_t;

  localparam int FLAG_SYS_BIT   = 7;
  localparam int FLAG_STATS_BIT = 6;
  localparam int FLAG_LAST_BIT  = 1;

  localparam logic [7:0]  STATS_FLAGS        = 8'b1100_0010;
  localparam logic [15:0] HEARTBEAT_ADDR     = 16'hC0FF;
  localparam logic [15:0] STATS_ADDR_DEFAULT = 16'hC0FE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT
  } arb_state_t;

endpackage

// File: rtl/cam_stream_arbiter_rr.sv
// Round-robin picker over N request bits. The pick is combinational;
// the search pointer moves past the winner only when advance is high.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  input  logic [N-1:0]                   req,
  input  logic                           advance,
  output logic [N-1:0]                   grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
  output logic                           any
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_reg, ptr_next;

  // Walk from farthest to nearest so the last hit is the closest to ptr_reg.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(ptr_reg) + off;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        any        = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (advance && any) begin
      ptr_next = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/cam_stream_arbiter.sv
// Shares the CAM serializer between N_REQ sources and a periodic stats
// packet: source 0 first, then stats, then round-robin over the rest.
module cam_stream_arbiter
  import cam_stream_pkg::*;
#(
  parameter int          N_REQ        = 4,
  parameter int          STATS_PERIOD = 1_000_000,
  parameter logic [15:0] STATS_ADDR   = STATS_ADDR_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [N_REQ*32-1:0]  req_data_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic [N_REQ-1:0]     drop_i,
  input  logic                 ser_busy_i,
  output logic                 ser_wr_o,
  output logic [31:0]          ser_data_o,
  output logic [3:0]           grant_id_o,
  output logic                 active_o,
  output logic [7:0]           drop_cnt_o
);

  localparam int          NRR        = N_REQ - 1;
  localparam int          RIW        = (NRR > 1) ? $clog2(NRR) : 1;
  localparam logic [31:0] TIMER_LAST = (STATS_PERIOD == 0) ? 32'd0 : 32'(STATS_PERIOD - 1);

  arb_state_t  state_reg, state_next;
  logic [31:0] ser_data_reg;
  logic [3:0]  grant_id_reg;
  logic [7:0]  drop_cnt_reg, drop_cnt_next;
  logic [31:0] timer_reg;
  logic        stats_pending_reg;

  logic [31:0] src_data [N_REQ];
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign src_data[gi] = req_data_i[32*gi +: 32];
    end
  endgenerate

  logic [NRR-1:0] rr_req, rr_grant;
  logic [RIW-1:0] rr_idx;
  logic           rr_any;
  logic           can_grant, stats_elig, grant_src0, grant_stats, grant_rr, any_grant;
  logic [31:0]    win_data;
  logic [3:0]     win_id;
  packet_t        stats_pkt;
  logic [3:0]     drop_pop;
  logic [8:0]     drop_sum;
  logic           timer_expire;

  assign rr_req = enable_i ? req_valid_i[N_REQ-1:1] : '0;

  rr_arbiter #(.N(NRR)) u_rr (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .req       (rr_req),
    .advance   (grant_rr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

  assign can_grant   = rst_n && (state_reg == ST_IDLE) && !ser_busy_i;
  assign stats_elig  = stats_pending_reg && enable_i;
  assign grant_src0  = can_grant && req_valid_i[0];
  assign grant_stats = can_grant && !req_valid_i[0] && stats_elig;
  assign grant_rr    = can_grant && !req_valid_i[0] && !stats_elig && rr_any;
  assign any_grant   = grant_src0 || grant_stats || grant_rr;

  assign stats_pkt = '{addr: STATS_ADDR, data: drop_cnt_reg, flags: STATS_FLAGS};

  always_comb begin
    req_ready_o = '0;
    win_data    = src_data[int'(rr_idx) + 1];
    win_id      = 4'(int'(rr_idx) + 1);
    if (grant_src0) begin
      req_ready_o[0] = 1'b1;
      win_data       = src_data[0];
      win_id         = 4'd0;
    end else if (grant_stats) begin
      win_data = stats_pkt;
      win_id   = 4'(N_REQ);
    end else if (grant_rr) begin
      req_ready_o[N_REQ-1:1] = rr_grant;
    end
  end

  // A guard cycle that already sees busy low returns straight to IDLE so the
  // next grant can land three cycles after the previous one.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (any_grant)   state_next = ST_ISSUE;
      ST_ISSUE:                  state_next = ST_GUARD;
      ST_GUARD:                  state_next = ser_busy_i ? ST_WAIT : ST_IDLE;
      ST_WAIT:  if (!ser_busy_i) state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    drop_pop = '0;
    for (int k = 0; k < N_REQ; k++) drop_pop = drop_pop + 4'(drop_i[k]);
    drop_sum      = {1'b0, drop_cnt_reg} + 9'(drop_pop);
    drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    // The stats packet carries the old count; this cycle's drops start the new one.
    if (grant_stats) drop_cnt_next = 8'(drop_pop);
  end

  assign timer_expire = (STATS_PERIOD != 0) && (timer_reg == TIMER_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      ser_data_reg      <= '0;
      grant_id_reg      <= '0;
      drop_cnt_reg      <= '0;
      timer_reg         <= '0;
      stats_pending_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      drop_cnt_reg      <= drop_cnt_next;
      stats_pending_reg <= (stats_pending_reg && !grant_stats) || timer_expire;
      if (STATS_PERIOD == 0 || timer_expire) timer_reg <= '0;
      else                                   timer_reg <= timer_reg + 32'd1;
      if (any_grant) begin
        ser_data_reg <= win_data;
        grant_id_reg <= win_id;
      end
    end
  end

  assign ser_wr_o   = (state_reg == ST_ISSUE);
  assign ser_data_o = ser_data_reg;
  assign grant_id_o = grant_id_reg;
  assign active_o   = (state_reg != ST_IDLE);
  assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: doc/cam_stream_arbiter.md
Name: cam_stream_arbiter

Overview:
- Shares the single CAM nibble serializer between N_REQ packet sources (reset marker, bus capture, heartbeat, host/control) plus an internal periodic statistics source.
- Source 0 has strict priority. Sources 1..N_REQ-1 are round-robin. The stats packet sits between them in priority.
- Sequences the serializer's one-cycle write strobe against its busy flag. Sits between the packet-forming logic and cam_serializer in the ESP32 streaming path.

Parameters:
- N_REQ, 4, number of external requesters (2..8); index 0 is strict priority.
- STATS_PERIOD, 1_000_000, clk_i cycles between stats packets; 0 disables the stats source.
- STATS_ADDR, 16'hC0FE, address field of the stats packet.

Ports:
- clk_i  in  1  logic clock (same domain as serializer)
- rst_n  in  1  synchronous, active-low reset
- enable_i  in  1  gates grants to sources 1..N_REQ-1 and stats; source 0 is always served
- req_valid_i  in  N_REQ  per-source packet pending
- req_data_i  in  N_REQ*32  per-source packet, source k at [32k+31:32k], format {addr16, data8, flags8}
- req_ready_o  out  N_REQ  one-hot accept pulse; source must drop or advance valid/data next cycle
- drop_i  in  N_REQ  per-source one-cycle pulse: packet discarded upstream
- ser_busy_i  in  1  serializer busy
- ser_wr_o  out  1  one-cycle write strobe to serializer
- ser_data_o  out  32  packet to serializer, stable from the ser_wr_o cycle until the next grant
- grant_id_o  out  4  index of the last granted source; N_REQ means stats
- active_o  out  1  high whenever FSM is not IDLE
- drop_cnt_o  out  8  current saturating drop count

Behaviour:
- Reset (rst_n low at a clk_i edge) forces:
  - FSM to IDLE; ser_wr_o=0; ser_data_o=0; req_ready_o=0; grant_id_o=0; active_o=0
  - drop_cnt=0, stats timer=0, stats_pending=0, rr_ptr=1
  - Reset mid-transfer abandons the packet. No ready is issued for it.
- FSM states:
  - IDLE: if ser_busy_i=0 and any eligible request, select winner, assert req_ready_o[winner] combinationally this cycle, latch data into ser_data_o, go ISSUE.
  - ISSUE: ser_wr_o=1 for exactly one cycle, go GUARD.
  - GUARD: one cycle, lets serializer raise busy, go WAIT.
  - WAIT: stay until ser_busy_i=0, then IDLE.
  - No selection while ser_busy_i=1 in IDLE.
- Latency: a grant in cycle t gives ser_wr_o at t+1. The earliest next grant is t+3, and only if busy has already fallen.
- Eligibility/priority, evaluated in IDLE only:
  1. Source 0 if req_valid_i[0].
  2. Stats if stats_pending && enable_i.
  3. Sources 1..N_REQ-1 if enable_i, scanning round-robin from rr_ptr upward with wrap (N_REQ-1 wraps to 1).
- rr_ptr update: after a round-robin grant to k, rr_ptr = k+1, wrapping to 1. rr_ptr is unchanged on source 0 or stats grants.
- Stats source:
  - Timer counts clk_i cycles. On reaching STATS_PERIOD-1 it wraps to 0 and sets stats_pending.
  - An expiry while already pending is absorbed; no queueing.
  - Stats packet = {STATS_ADDR, drop_cnt, 8'b1100_0010}.
  - On stats grant: stats_pending cleared; drop_cnt reloaded with popcount(drop_i) of that same cycle (not lost).
  - STATS_PERIOD=0: timer held at 0, stats_pending never set.
- drop_cnt: adds popcount(drop_i) each cycle, saturates at 255, never wraps. drop_cnt_o mirrors it.
- Requester contract:
  - req_data_i must be stable while valid is high and ready is low.
  - Dropping valid before ready is legal; that source is simply not considered.
- grant_id_o updates on each grant cycle and holds otherwise.
- enable_i falling while in ISSUE/GUARD/WAIT does not abort the transfer in flight.

Decomposition:
- Shared package cam_stream_pkg:
  - packet typedef (addr/data/flags struct, 32 bits)
  - flag bit positions
  - STATS_FLAGS = 8'b1100_0010, HEARTBEAT_ADDR = 16'hC0FF, STATS_ADDR default
  - FSM state enum
- One natural sub-module, rr_arbiter: round-robin pick over N_REQ-1 bits with rr_ptr. Combinational pick plus registered pointer, reusable elsewhere.

Test Plan:
- Single source 2 valid, data 32'hC030_5A80, busy idle -> ready[2] at t, ser_wr_o at t+1 with data C0305A80, active_o high until busy falls.
- Sources 1,2,3 valid continuously, busy 10 cycles per packet -> grant order 1,2,3,1,2,3; each write separated by at least 3 + 10 cycles.
- Source 0 and source 1 valid together with stats_pending -> order: 0, stats, 1.
- STATS_PERIOD=50, three drop_i pulses on sources 1 and 2 (4 drops total), one coincident with the stats grant -> stats packet data C0FE_03C2; drop_cnt_o=1 afterwards.
- 300 drop pulses with no stats grant -> drop_cnt_o saturates at 255, never 0.
- rst_n low during WAIT with source 1 still valid -> next cycle IDLE, outputs zero, rr_ptr=1. After release, source 1 is re-granted once busy is low.
